// File: rtl/pot_smoother_pkg.sv
// pot_smoother_pkg: shared types and default configuration for the pot
// conditioning block (conversion sequencer states, default widths, and a
// helper that sizes channel-index signals).
package pot_smoother_pkg;

    localparam int DEF_N           = 10;
    localparam int DEF_CHANNELS    = 2;
    localparam int DEF_SHIFT       = 3;
    localparam int DEF_HYST        = 4;
    localparam int DEF_SYNC_STAGES = 2;

    // Conversion sequencer states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        FILTER  = 2'd2,
        COMPARE = 2'd3
    } state_t;

    // Width of an index over 'count' items; never narrower than one bit.
    function automatic int idx_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// sync_edge: multi-flop synchronizer for a level coming from a foreign
// clock domain, plus a rising-edge detector on the synchronized level.
// rise_pulse is high for exactly the one cycle in which the synchronized
// level is 1 and was 0 in the previous cycle.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic level_out,
    output logic rise_pulse
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_level_d;

    // Shift the foreign level through the synchronizer and keep last level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync    <= '0;
            r_level_d <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the
            // pre-edge value, so the chain shifts by exactly one stage.
            r_sync    <= {r_sync[SYNC_STAGES-2:0], async_in};
            r_level_d <= r_sync[SYNC_STAGES-1];
        end
    end

    assign level_out  = r_sync[SYNC_STAGES-1];
    assign rise_pulse = r_sync[SYNC_STAGES-1] & ~r_level_d;

endmodule

// File: rtl/pot_smoother.sv
// pot_smoother: conditions multi-channel potentiometer words from the pot
// ADC. Each new conversion is snapshotted, every channel is passed through
// an exponential moving average (alpha = 1/2^SHIFT) and a hysteresis
// deadband, and the selected channel is presented as a held word with a
// one-cycle update strobe.
// Build option: define POT_SMOOTHER_OVERRUN_EN to add the overrun_cnt
// output counting conversion edges dropped while one was already pending.
module pot_smoother
    import pot_smoother_pkg::*;
#(
    parameter int  N           = DEF_N,
    parameter int  CHANNELS    = DEF_CHANNELS,
    parameter int  SHIFT       = DEF_SHIFT,
    parameter int  HYST        = DEF_HYST,
    parameter int  SYNC_STAGES = DEF_SYNC_STAGES,
    localparam int SEL_W       = idx_width(CHANNELS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CHANNELS*N-1:0] adc_in,
    input  logic                  adc_valid,
    input  logic [SEL_W-1:0]      sel,
    output logic [N-1:0]          smooth_out,
    output logic                  smooth_valid
`ifdef POT_SMOOTHER_OVERRUN_EN
    ,
    output logic [7:0]            overrun_cnt
`endif
);

    localparam int              AW      = N + SHIFT;
    localparam int              CH_W    = idx_width(CHANNELS);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);
    localparam logic [N-1:0]    HYST_W  = N'(HYST);

    // Conversion edge detection
    logic w_level;
    logic w_rise;
    logic w_edge;

    // Sequencer state
    state_t          r_state;
    logic [CH_W-1:0] r_ch;
    logic            r_primed;
    logic            r_pending;

    // Per-channel storage
    logic [N-1:0]  r_snap [CHANNELS];
    logic [AW-1:0] r_acc  [CHANNELS];
    logic [N-1:0]  r_held [CHANNELS];

    // Per-channel hysteresis results
    logic [N-1:0]          w_f         [CHANNELS];
    logic [N-1:0]          w_held_next [CHANNELS];
    logic [CHANNELS-1:0]   w_move;

    // EMA datapath for the channel currently being filtered
    logic [N-1:0]  w_x;
    logic [AW-1:0] w_acc_cur;
    logic [AW-1:0] w_decayed;
    logic [AW-1:0] w_acc_new;

    // Output selection
    logic             w_compare;
    logic [SEL_W-1:0] w_sel;
    logic [SEL_W-1:0] r_sel_prev;
    logic             w_out_upd;
    logic [N-1:0]     r_smooth_out;
    logic             r_smooth_valid;

    sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clk       (clk),
        .reset     (reset),
        .async_in  (adc_valid),
        .level_out (w_level),
        .rise_pulse(w_rise)
    );

    // The rise pulse already implies the level; qualifying on both keeps the
    // start condition explicitly tied to the synchronized level.
    assign w_edge    = w_rise & w_level;
    assign w_compare = (r_state == COMPARE);

    // Conversion sequencer: capture, filter one channel per cycle, compare.
    // An edge arriving mid-conversion is remembered once in r_pending and
    // replayed straight from COMPARE; further edges are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_ch      <= '0;
            r_primed  <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_edge) begin
                        r_state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (w_edge) begin
                        r_pending <= 1'b1;
                    end
                    r_ch    <= '0;
                    r_state <= FILTER;
                end
                FILTER: begin
                    if (w_edge) begin
                        r_pending <= 1'b1;
                    end
                    if (r_ch == LAST_CH) begin
                        r_state <= COMPARE;
                    end else begin
                        r_ch <= r_ch + CH_W'(1);
                    end
                end
                COMPARE: begin
                    r_primed  <= 1'b1;
                    r_pending <= 1'b0;
                    r_state   <= (r_pending || w_edge) ? CAPTURE : IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Snapshot every channel once so filtering sees one coherent sample set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: these small register arrays are reset explicitly because
            // a re-prime after reset must start from known zero state.
            for (int c = 0; c < CHANNELS; c++) begin
                r_snap[c] <= '0;
            end
        end else if (r_state == CAPTURE) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_snap[c] <= adc_in[c*N +: N];
            end
        end
    end

    // acc - (acc >> SHIFT) never underflows, and adding a word of N bits
    // keeps the sum within N+SHIFT bits, so no carry bit is needed.
    assign w_x       = r_snap[r_ch];
    assign w_acc_cur = r_acc[r_ch];
    assign w_decayed = w_acc_cur - (w_acc_cur >> SHIFT);
    assign w_acc_new = r_primed ? (w_decayed + AW'(w_x))
                                : {w_x, {SHIFT{1'b0}}};

    // Update the EMA accumulator of one channel per FILTER cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_acc[c] <= '0;
            end
        end else if (r_state == FILTER) begin
            r_acc[r_ch] <= w_acc_new;
        end
    end

    // Hysteresis per channel: move the held value only on a large enough
    // change, on the first compare after reset, or to reach either rail.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_hyst
        logic [N-1:0] w_diff;
        logic         w_rail;

        assign w_f[c]    = r_acc[c][AW-1:SHIFT];
        assign w_diff    = (w_f[c] >= r_held[c]) ? (w_f[c] - r_held[c])
                                                 : (r_held[c] - w_f[c]);
        assign w_rail    = ((w_f[c] == '0) || (w_f[c] == '1)) &&
                           (w_f[c] != r_held[c]);
        assign w_move[c] = !r_primed || (w_diff >= HYST_W) || w_rail;
        assign w_held_next[c] = (w_compare && w_move[c]) ? w_f[c] : r_held[c];
    end

    // Commit the held values at the end of each COMPARE cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_held[c] <= '0;
            end
        end else if (w_compare) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_held[c] <= w_held_next[c];
            end
        end
    end

    // Out-of-range selects fall back to channel 0.
    if ((1 << SEL_W) == CHANNELS) begin : g_sel_full
        assign w_sel = sel;
    end else begin : g_sel_clamp
        assign w_sel = (int'(sel) < CHANNELS) ? sel : '0;
    end

    // Looking at w_held_next lets a compare update and a select change that
    // land in the same cycle produce one pulse carrying the newest value.
    assign w_out_upd = (w_compare &&
                        (!r_primed || (w_held_next[w_sel] != r_held[w_sel]))) ||
                       (w_sel != r_sel_prev);

    // Register the presented word and its one-cycle update strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sel_prev     <= '0;
            r_smooth_out   <= '0;
            r_smooth_valid <= 1'b0;
        end else begin
            r_sel_prev     <= w_sel;
            r_smooth_valid <= w_out_upd;
            if (w_out_upd) begin
                r_smooth_out <= w_held_next[w_sel];
            end
        end
    end

    assign smooth_out   = r_smooth_out;
    assign smooth_valid = r_smooth_valid;

`ifdef POT_SMOOTHER_OVERRUN_EN
    logic       w_drop;
    logic [7:0] r_overrun_cnt;

    // An edge is lost when one is already waiting behind a busy conversion.
    assign w_drop = w_edge && (r_state != IDLE) && r_pending;

    // Count dropped edges, saturating so a long overrun burst stays visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overrun_cnt <= 8'd0;
        end else if (w_drop && (r_overrun_cnt != 8'hFF)) begin
            r_overrun_cnt <= r_overrun_cnt + 8'd1;
        end
    end

    assign overrun_cnt = r_overrun_cnt;
`endif

endmodule

// File: tb/tb_pot_smoother.sv
// tb_pot_smoother: directed stimulus for pot_smoother with a conversion-level
// reference model checked against the outputs on every cycle, plus
// hand-computed expectations for the key scenarios.
module tb_pot_smoother;

    localparam int N     = 10;
    localparam int CH    = 2;
    localparam int SHIFT = 3;
    localparam int HYST  = 4;
    localparam int SS    = 2;
    localparam int MAXV  = (1 << N) - 1;

    logic            clk;
    logic            reset;
    logic [CH*N-1:0] adc_in;
    logic            adc_valid;
    logic            sel;
    logic [N-1:0]    smooth_out;
    logic            smooth_valid;
`ifdef POT_SMOOTHER_OVERRUN_EN
    logic [7:0]      overrun_cnt;
`endif

    int n_cmp;
    int n_bad;
    int pulses;
    int lat;

    pot_smoother #(
        .N          (N),
        .CHANNELS   (CH),
        .SHIFT      (SHIFT),
        .HYST       (HYST),
        .SYNC_STAGES(SS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .adc_in      (adc_in),
        .adc_valid   (adc_valid),
        .sel         (sel),
        .smooth_out  (smooth_out),
        .smooth_valid(smooth_valid)
`ifdef POT_SMOOTHER_OVERRUN_EN
        ,
        .overrun_cnt (overrun_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model. A conversion is tracked only by how many cycles have
    // passed since its start edge; all channels are filtered and compared
    // in one step when the conversion completes.
    // ------------------------------------------------------------------
    int m_acc  [CH];
    int m_held [CH];
    int m_snap [CH];
    int m_phase;       // 0 = idle, else cycles since the start edge
    int m_out;
    int m_prev_sel;
    int m_drops;
    bit m_pend;
    bit m_primed;
    bit m_valid;
    bit m_sync [SS];
    bit m_lvl_d;

    always @(posedge clk or posedge reset) begin
        int hn [CH];
        int f;
        int d;
        bit lvl;
        bit rise;
        bit first;
        bit fire;
        if (reset) begin
            for (int c = 0; c < CH; c++) begin
                m_acc[c] = 0; m_held[c] = 0; m_snap[c] = 0;
            end
            for (int i = 0; i < SS; i++) m_sync[i] = 1'b0;
            m_lvl_d = 1'b0; m_phase = 0; m_out = 0; m_prev_sel = 0;
            m_drops = 0; m_pend = 1'b0; m_primed = 1'b0; m_valid = 1'b0;
        end else begin
            lvl  = m_sync[SS-1];
            rise = lvl && !m_lvl_d;
            m_lvl_d = lvl;
            for (int i = SS - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
            m_sync[0] = adc_valid;

            for (int c = 0; c < CH; c++) hn[c] = m_held[c];
            first = 1'b0;
            if (m_phase == CH + 2) begin
                first = !m_primed;
                for (int c = 0; c < CH; c++) begin
                    if (m_primed) m_acc[c] = m_acc[c] + m_snap[c] - (m_acc[c] >> SHIFT);
                    else          m_acc[c] = m_snap[c] << SHIFT;
                    f = m_acc[c] >> SHIFT;
                    d = (f > hn[c]) ? f - hn[c] : hn[c] - f;
                    if (!m_primed || d >= HYST || ((f == 0 || f == MAXV) && f != hn[c]))
                        hn[c] = f;
                end
                m_primed = 1'b1;
            end
            fire = ((m_phase == CH + 2) && (first || hn[int'(sel)] != m_held[int'(sel)])) ||
                   (int'(sel) != m_prev_sel);
            m_valid = fire;
            if (fire) m_out = hn[int'(sel)];
            for (int c = 0; c < CH; c++) m_held[c] = hn[c];
            m_prev_sel = int'(sel);

            if (m_phase == 0) begin
                if (rise) m_phase = 1;
            end else if (m_phase == CH + 2) begin
                if (rise && m_pend && m_drops < 255) m_drops++;
                m_phase = (m_pend || rise) ? 1 : 0;
                m_pend  = 1'b0;
            end else begin
                if (m_phase == 1)
                    for (int c = 0; c < CH; c++) m_snap[c] = int'(adc_in[c*N +: N]);
                if (rise) begin
                    if (m_pend) begin
                        if (m_drops < 255) m_drops++;
                    end else begin
                        m_pend = 1'b1;
                    end
                end
                m_phase++;
            end
        end
    end

    // Every-cycle comparison of the outputs against the model.
    always @(negedge clk) begin
        if (!reset) begin
            check("smooth_out",   32'(smooth_out),   32'(m_out));
            check("smooth_valid", 32'(smooth_valid), 32'(m_valid));
`ifdef POT_SMOOTHER_OVERRUN_EN
            check("overrun_cnt",  32'(overrun_cnt),  32'(m_drops));
`endif
        end
    end

    // One conversion: raise adc_valid for 4 cycles, then 10 idle cycles.
    // Counts strobes and the clock count from raising adc_valid to the first.
    task automatic conv(input int ch0, input int ch1, output int np, output int fl);
        adc_in = {N'(ch1), N'(ch0)};
        np = 0;
        fl = -1;
        for (int k = 1; k <= 14; k++) begin
            adc_valid = (k <= 4);
            @(negedge clk);
            if (smooth_valid) begin
                np++;
                if (fl < 0) fl = k;
            end
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        adc_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int total;
        n_cmp = 0; n_bad = 0;
        reset = 1'b1; adc_valid = 1'b0; adc_in = '0; sel = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_out",   32'(smooth_out),   0);
        check("reset_valid", 32'(smooth_valid), 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_valid", 32'(smooth_valid), 0);

        // First conversion primes: one strobe 5 cycles after the sync'd edge.
        conv(512, 100, pulses, lat);
        check("prime_pulses", pulses, 1);
        check("prime_latency", lat, SS + 5);
        check("prime_out", 32'(smooth_out), 512);
        check("model_acc0_prime", m_acc[0], 4096);
        check("model_acc1_prime", m_acc[1], 800);

        // Large step: 4096 + 600 - 512 = 4184, filtered 523.
        conv(600, 100, pulses, lat);
        check("step_pulses", pulses, 1);
        check("step_out", 32'(smooth_out), 523);
        check("model_acc0_step", m_acc[0], 4184);

        // Small jitter around 512 stays inside the deadband.
        do_reset();
        conv(512, 100, pulses, lat);
        total = 0;
        for (int i = 0; i < 50; i++) begin
            conv((i % 2 == 0) ? 514 : 510, 100, pulses, lat);
            total += pulses;
        end
        check("jitter_pulses", total, 0);
        check("jitter_out", 32'(smooth_out), 512);

        // Upper rail reached exactly, then quiet.
        for (int i = 0; i < 100; i++) conv(MAXV, 100, pulses, lat);
        check("rail_hi_out", 32'(smooth_out), MAXV);
        total = 0;
        for (int i = 0; i < 10; i++) begin
            conv(MAXV, 100, pulses, lat);
            total += pulses;
        end
        check("rail_hi_quiet", total, 0);

        // Lower rail reached exactly, then quiet.
        for (int i = 0; i < 100; i++) conv(0, 100, pulses, lat);
        check("rail_lo_out", 32'(smooth_out), 0);
        total = 0;
        for (int i = 0; i < 10; i++) begin
            conv(0, 100, pulses, lat);
            total += pulses;
        end
        check("rail_lo_quiet", total, 0);

        // Select toggles without conversions.
        do_reset();
        conv(512, 100, pulses, lat);
        sel = 1'b1;
        @(negedge clk);
        check("sel1_valid", 32'(smooth_valid), 1);
        check("sel1_out", 32'(smooth_out), 100);
        @(negedge clk);
        check("sel1_quiet", 32'(smooth_valid), 0);
        sel = 1'b0;
        @(negedge clk);
        check("sel0_valid", 32'(smooth_valid), 1);
        check("sel0_out", 32'(smooth_out), 512);

        // Edges at cycles 0, 2, 4: second is pending and processed, third
        // dropped. 523 then 4261>>3 = 532; a third update would give 541.
        do_reset();
        conv(512, 100, pulses, lat);
        adc_in = {N'(100), N'(600)};
        total = 0;
        for (int k = 1; k <= 24; k++) begin
            adc_valid = (k <= 5) && (k % 2 == 1);
            @(negedge clk);
            if (smooth_valid) total++;
        end
        check("burst_pulses", total, 2);
        check("burst_out", 32'(smooth_out), 532);
`ifdef POT_SMOOTHER_OVERRUN_EN
        check("burst_overrun", 32'(overrun_cnt), 1);
`endif

        // Reset during FILTER, then the next conversion re-primes.
        adc_in = {N'(200), N'(700)};
        for (int k = 1; k <= 4; k++) begin
            adc_valid = 1'b1;
            @(negedge clk);
        end
        reset     = 1'b1;
        adc_valid = 1'b0;
        #1;
        check("midreset_out",   32'(smooth_out),   0);
        check("midreset_valid", 32'(smooth_valid), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        conv(700, 200, pulses, lat);
        check("reprime_pulses", pulses, 1);
        check("reprime_out", 32'(smooth_out), 700);
        check("model_acc0_reprime", m_acc[0], 5600);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
